// File: rtl/inst_queue_ctrl.sv
// Instruction queue between fetcher and decoder.
// Circular buffer of {pc, inst} with almost-full throttle and ROB flush.
module inst_queue_ctrl #(
  parameter int DEPTH_LOG = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_in,
  input  logic                 valid_if_in,
  input  logic [31:0]          inst_if_in,
  input  logic [31:0]          pc_if_in,
  output logic                 full_if_out,
  output logic                 rdy_dc_out,
  output logic [31:0]          inst_dc_out,
  output logic [31:0]          pc_dc_out,
  input  logic                 stall_dp_in,
  output logic [DEPTH_LOG:0]   count_out,
  output logic                 err_ovf_out
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] DEPTH_C = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] AF_TH = (DEPTH_LOG+1)'(DEPTH - AF_MARGIN);

  logic [63:0]          mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] head_q, head_d;
  logic [DEPTH_LOG-1:0] tail_q, tail_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic                 err_q, err_d;
  logic                 pop, push, ovf, act;
  logic [63:0]          head_entry;

  assign act = rdy_in & ~clear_in;

  always_comb begin
    pop     = act & rdy_dc_out & ~stall_dp_in;
    push    = act & valid_if_in & ((count_q < DEPTH_C) | pop);
    ovf     = act & valid_if_in & (count_q == DEPTH_C) & ~pop;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q | ovf;
    if (rdy_in & clear_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + 1'b1;
      if (push) tail_d = tail_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Payload storage is not reset; validity comes from count_q.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[tail_q] <= {pc_if_in, inst_if_in};
  end

  assign head_entry  = mem_q[head_q];
  assign rdy_dc_out  = (count_q != '0);
  assign inst_dc_out = rdy_dc_out ? head_entry[31:0]  : 32'h0;
  assign pc_dc_out   = rdy_dc_out ? head_entry[63:32] : 32'h0;
  assign full_if_out = (count_q >= AF_TH);
  assign count_out   = count_q;
  assign err_ovf_out = err_q;

endmodule

// File: tb/tb_inst_queue_ctrl.sv
// Bench for inst_queue_ctrl: queue-based reference model
// compared every cycle, plus directed literal checks.
module tb_inst_queue_ctrl;

  logic        clk = 0;
  logic        rst = 1;
  logic        rdy = 1;
  logic        clear = 0;
  logic        valid = 0;
  logic [31:0] inst = 0;
  logic [31:0] pc = 0;
  logic        stall = 0;
  logic        full_o, rdy_o, err_o;
  logic [31:0] inst_o, pc_o;
  logic [4:0]  count_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] mq[$];
  bit          merr;

  inst_queue_ctrl #(.DEPTH_LOG(4), .AF_MARGIN(2)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clear),
    .valid_if_in(valid), .inst_if_in(inst), .pc_if_in(pc),
    .full_if_out(full_o), .rdy_dc_out(rdy_o),
    .inst_dc_out(inst_o), .pc_dc_out(pc_o),
    .stall_dp_in(stall), .count_out(count_o), .err_ovf_out(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of {pc, inst}
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      merr = 0;
    end else if (rdy) begin
      if (clear) mq.delete();
      else begin
        bit p, w;
        p = (mq.size() > 0) && !stall;
        w = valid && (mq.size() < 16 || p);
        if (valid && mq.size() == 16 && !p) merr = 1;
        if (p) void'(mq.pop_front());
        if (w) mq.push_back({pc, inst});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      int n;
      n = mq.size();
      chk("m_count", 32'(count_o), 32'(n));
      chk("m_rdy", 32'(rdy_o), 32'(n > 0));
      chk("m_full", 32'(full_o), 32'(n >= 14));
      chk("m_err", 32'(err_o), 32'(merr));
      chk("m_inst", inst_o, n > 0 ? mq[0][31:0] : 32'h0);
      chk("m_pc", pc_o, n > 0 ? mq[0][63:32] : 32'h0);
    end
  end

  task automatic cyc(input logic v, input logic [31:0] p,
                     input logic [31:0] i, input logic s,
                     input logic c, input logic r);
    valid = v; pc = p; inst = i; stall = s; clear = c; rdy = r;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    valid = 0; clear = 0; stall = 0; rdy = 1;
    @(negedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    @(negedge clk);
    #1;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_rdy", 32'(rdy_o), 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_full", 32'(full_o), 0);
    chk("rst_err", 32'(err_o), 0);
    rst = 0;

    // push 3 with stall, then drain in order
    cyc(1, 32'h0, 32'h00000013, 1, 0, 1);
    cyc(1, 32'h4, 32'h00100093, 1, 0, 1);
    cyc(1, 32'h8, 32'h00200113, 1, 0, 1);
    chk("t1_count", 32'(count_o), 3);
    chk("t1_inst", inst_o, 32'h00000013);
    chk("t1_pc", pc_o, 32'h0);
    cyc(0, 0, 0, 1, 0, 1);
    chk("t1_hold", inst_o, 32'h00000013);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t1_pop1", inst_o, 32'h00100093);
    chk("t1_pop1pc", pc_o, 32'h4);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t1_pop2", inst_o, 32'h00200113);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t1_empty", 32'(rdy_o), 0);

    // fill to 16, then overflow
    for (int k = 0; k < 16; k++) begin
      cyc(1, 32'h1000 + 32'(4*k), 32'hA000 + 32'(k), 1, 0, 1);
      if (k == 12) chk("t2_af13", 32'(full_o), 0);
      if (k == 13) chk("t2_af14", 32'(full_o), 1);
    end
    chk("t2_count16", 32'(count_o), 16);
    cyc(1, 32'hDEAD, 32'hBEEF, 1, 0, 1);
    chk("t2_ovf_err", 32'(err_o), 1);
    chk("t2_ovf_cnt", 32'(count_o), 16);
    chk("t2_ovf_head", pc_o, 32'h1000);

    // push+pop at full, then mixed traffic across wrap
    do_reset();
    for (int k = 0; k < 16; k++)
      cyc(1, 32'h2000 + 32'(4*k), 32'hB000 + 32'(k), 1, 0, 1);
    cyc(1, 32'h3000, 32'hC000, 0, 0, 1);
    chk("t3_cnt", 32'(count_o), 16);
    chk("t3_head", pc_o, 32'h2004);
    chk("t3_err", 32'(err_o), 0);
    for (int k = 0; k < 40; k++)
      cyc(k % 3 != 0, $urandom, $urandom, k % 4 == 0, 0, 1);

    // clear at count 5 with a push pending
    cyc(0, 0, 0, 1, 1, 1);
    for (int k = 0; k < 5; k++)
      cyc(1, 32'h40 + 32'(k), 32'h50 + 32'(k), 1, 0, 1);
    chk("t4_cnt5", 32'(count_o), 5);
    cyc(1, 32'h77, 32'h77, 0, 1, 1);
    chk("t4_clr_cnt", 32'(count_o), 0);
    chk("t4_clr_rdy", 32'(rdy_o), 0);
    cyc(1, 32'h100, 32'h00500293, 1, 0, 1);
    chk("t4_head", pc_o, 32'h100);
    chk("t4_cnt1", 32'(count_o), 1);

    // rdy_in low freezes everything
    for (int k = 0; k < 4; k++)
      cyc(1, 32'h999, 32'h999, 0, 1, 0);
    chk("t5_cnt", 32'(count_o), 1);
    chk("t5_pc", pc_o, 32'h100);

    // async reset mid-cycle at count 7
    for (int k = 0; k < 6; k++)
      cyc(1, 32'h200 + 32'(k), 32'h300 + 32'(k), 1, 0, 1);
    chk("t6_cnt7", 32'(count_o), 7);
    valid = 0;
    #1;
    rst = 1;
    #1;
    chk("t6_async_cnt", 32'(count_o), 0);
    chk("t6_async_rdy", 32'(rdy_o), 0);
    chk("t6_async_pc", pc_o, 0);
    chk("t6_async_inst", inst_o, 0);
    #1;
    rst = 0;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
